// File: rtl/button_events_pkg.sv
// Shared timing constants for button event generation, so the firmware-visible
// press/long/repeat timing is defined in one place.
package button_events_pkg;

  localparam int TICK_HZ              = 1000;
  localparam int DEFAULT_LONG_TICKS   = 1000;
  localparam int DEFAULT_REPEAT_TICKS = 200;

  // True when a non-negative value can be represented in an unsigned field of the given width.
  function automatic bit fits_width(input longint value, input int width);
    return (value >= 0) && (value < (longint'(1) << width));
  endfunction

endpackage

// File: rtl/button_events.sv
// Turns a debounced button level into single-cycle press, release, short-click,
// long-press and auto-repeat events, timed in tick_en strobes.
module button_events
  import button_events_pkg::*;
#(
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int CNT_WIDTH    = 12,
  parameter int LONG_TICKS   = DEFAULT_LONG_TICKS,
  parameter int REPEAT_TICKS = DEFAULT_REPEAT_TICKS
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_en,
  input  logic btn,
  output logic held,
  output logic press_evt,
  output logic release_evt,
  output logic short_evt,
  output logic long_evt,
  output logic repeat_evt
);

  typedef enum logic [1:0] {LOCKOUT, IDLE, PRESSED, HELD} state_t;

  if (LONG_TICKS < 1) begin : g_bad_long
    $error("button_events: LONG_TICKS must be at least 1");
  end
  if (!fits_width(longint'(LONG_TICKS) - 1, CNT_WIDTH)) begin : g_long_width
    $error("button_events: LONG_TICKS-1 does not fit in CNT_WIDTH");
  end
  if (REPEAT_TICKS < 0 || !fits_width(longint'(REPEAT_TICKS) - 1 + longint'(REPEAT_TICKS == 0), CNT_WIDTH)) begin : g_rep_width
    $error("button_events: REPEAT_TICKS-1 does not fit in CNT_WIDTH");
  end

  localparam logic [CNT_WIDTH-1:0] LONG_LAST   = CNT_WIDTH'(LONG_TICKS - 1);
  localparam logic [CNT_WIDTH-1:0] REPEAT_LAST =
    (REPEAT_TICKS == 0) ? '0 : CNT_WIDTH'(REPEAT_TICKS - 1);

  state_t                state;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  act;

  assign act = btn ^ ACTIVE_LOW;

  // A release always takes priority over a tick arriving in the same cycle,
  // so the counter never produces a long/repeat pulse on the way out.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= LOCKOUT;
      cnt         <= '0;
      held        <= 1'b0;
      press_evt   <= 1'b0;
      release_evt <= 1'b0;
      short_evt   <= 1'b0;
      long_evt    <= 1'b0;
      repeat_evt  <= 1'b0;
    end else begin
      press_evt   <= 1'b0;
      release_evt <= 1'b0;
      short_evt   <= 1'b0;
      long_evt    <= 1'b0;
      repeat_evt  <= 1'b0;
      case (state)
        LOCKOUT: begin
          held <= 1'b0;
          cnt  <= '0;
          if (!act) state <= IDLE;
        end
        IDLE: begin
          cnt <= '0;
          if (act) begin
            state     <= PRESSED;
            held      <= 1'b1;
            press_evt <= 1'b1;
          end else begin
            held <= 1'b0;
          end
        end
        PRESSED: begin
          if (!act) begin
            state       <= IDLE;
            held        <= 1'b0;
            cnt         <= '0;
            release_evt <= 1'b1;
            short_evt   <= 1'b1;
          end else if (tick_en) begin
            if (cnt == LONG_LAST) begin
              state    <= HELD;
              cnt      <= '0;
              long_evt <= 1'b1;
            end else begin
              cnt <= cnt + CNT_WIDTH'(1);
            end
          end
        end
        HELD: begin
          if (!act) begin
            state       <= IDLE;
            held        <= 1'b0;
            cnt         <= '0;
            release_evt <= 1'b1;
          end else if (tick_en && (REPEAT_TICKS != 0)) begin
            if (cnt == REPEAT_LAST) begin
              cnt        <= '0;
              repeat_evt <= 1'b1;
            end else begin
              cnt <= cnt + CNT_WIDTH'(1);
            end
          end
        end
        default: begin
          state <= LOCKOUT;
          held  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_events.sv
// Scoreboard bench for button_events: a tick-counting reference model predicts
// each cycle's outputs for a repeat-enabled and a repeat-disabled instance.
module tb_button_events;

  localparam int L = 4;
  localparam int R = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick_en = 1'b0;
  logic btn = 1'b0;

  logic held_a, press_a, rel_a, short_a, long_a, rep_a;
  logic held_b, press_b, rel_b, short_b, long_b, rep_b;

  int checks = 0;
  int errors = 0;
  int phase = 0;
  logic last_tick = 1'b0;

  int m_state [2];
  int m_ticks [2];
  logic [11:0] sb [$];

  int c_press, c_rel, c_short, c_long, c_rep, c_long0, c_rep0;

  always #5 clk = ~clk;

  button_events #(.ACTIVE_LOW(1'b1), .CNT_WIDTH(12), .LONG_TICKS(L), .REPEAT_TICKS(R)) dut (
    .clk(clk), .reset(reset), .tick_en(tick_en), .btn(btn),
    .held(held_a), .press_evt(press_a), .release_evt(rel_a),
    .short_evt(short_a), .long_evt(long_a), .repeat_evt(rep_a)
  );

  button_events #(.ACTIVE_LOW(1'b1), .CNT_WIDTH(12), .LONG_TICKS(L), .REPEAT_TICKS(0)) dut_norep (
    .clk(clk), .reset(reset), .tick_en(tick_en), .btn(btn),
    .held(held_b), .press_evt(press_b), .release_evt(rel_b),
    .short_evt(short_b), .long_evt(long_b), .repeat_evt(rep_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Output order {held, press, release, short, long, repeat}; timing is derived
  // from the absolute number of ticks seen since the press.
  task automatic modelStep(input int idx, input int rr, input logic rst, input logic tk,
                           input logic b, output logic [5:0] e);
    logic act;
    act = ~b;
    e = '0;
    if (rst) begin
      m_state[idx] = 0;
    end else begin
      case (m_state[idx])
        0: if (!act) m_state[idx] = 1;
        1: if (act) begin
          m_state[idx] = 2;
          m_ticks[idx] = 0;
          e[5] = 1'b1;
          e[4] = 1'b1;
        end
        default: begin
          if (!act) begin
            m_state[idx] = 1;
            e[3] = 1'b1;
            e[2] = (m_ticks[idx] < L);
          end else begin
            e[5] = 1'b1;
            if (tk) begin
              m_ticks[idx]++;
              if (m_ticks[idx] == L) e[1] = 1'b1;
              else if (rr != 0 && m_ticks[idx] > L && ((m_ticks[idx] - L) % rr) == 0) e[0] = 1'b1;
            end
          end
        end
      endcase
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic b);
    logic tk;
    logic [5:0] e0, e1;
    logic [11:0] exp_v;
    @(negedge clk);
    tk = (phase == 4);
    phase = (phase + 1) % 5;
    reset = rst;
    btn = b;
    tick_en = tk;
    last_tick = tk;
    modelStep(0, R, rst, tk, b, e0);
    modelStep(1, 0, rst, tk, b, e1);
    sb.push_back({e1, e0});
    @(posedge clk);
    #1;
    exp_v = sb.pop_front();
    checkOutput("outs_rep", {26'd0, held_a, press_a, rel_a, short_a, long_a, rep_a}, {26'd0, exp_v[5:0]});
    checkOutput("outs_norep", {26'd0, held_b, press_b, rel_b, short_b, long_b, rep_b}, {26'd0, exp_v[11:6]});
    c_press += int'(press_a);
    c_rel   += int'(rel_a);
    c_short += int'(short_a);
    c_long  += int'(long_a);
    c_rep   += int'(rep_a);
    c_long0 += int'(long_b);
    c_rep0  += int'(rep_b);
  endtask

  task automatic clearCounts();
    c_press = 0; c_rel = 0; c_short = 0; c_long = 0; c_rep = 0; c_long0 = 0; c_rep0 = 0;
  endtask

  task automatic holdTicks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      applyStimulus(1'b0, 1'b0);
      if (last_tick) k++;
    end
  endtask

  task automatic releaseFor(input int n);
    repeat (n) applyStimulus(1'b0, 1'b1);
  endtask

  initial begin
    bit done;
    clearCounts();

    // Test 1: button held through reset must never produce a press
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t1_reset_held", {31'd0, held_a}, 32'd0);
    clearCounts();
    repeat (20) applyStimulus(1'b0, 1'b0);
    checkOutput("t1_no_press_locked", c_press, 0);
    releaseFor(3);
    checkOutput("t1_no_release_locked", c_rel, 0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t1_press_once", c_press, 1);
    releaseFor(3);

    // Test 2: short click
    clearCounts();
    applyStimulus(1'b0, 1'b0);
    holdTicks(2);
    releaseFor(3);
    checkOutput("t2_press", c_press, 1);
    checkOutput("t2_release", c_rel, 1);
    checkOutput("t2_short", c_short, 1);
    checkOutput("t2_long", c_long, 0);

    // Test 3: long press with repeats
    clearCounts();
    applyStimulus(1'b0, 1'b0);
    holdTicks(9);
    releaseFor(3);
    checkOutput("t3_long", c_long, 1);
    checkOutput("t3_repeat", c_rep, 2);
    checkOutput("t3_release", c_rel, 1);
    checkOutput("t3_short", c_short, 0);
    checkOutput("t3_norep_repeat", c_rep0, 0);

    // Test 4: release coincides with the 4th tick
    clearCounts();
    applyStimulus(1'b0, 1'b0);
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (m_ticks[0] == L - 1 && phase == 4) begin
        applyStimulus(1'b0, 1'b1);
        done = 1'b1;
      end else begin
        applyStimulus(1'b0, 1'b0);
      end
    end
    checkOutput("t4_reached", {31'd0, done}, 32'd1);
    releaseFor(3);
    checkOutput("t4_long", c_long, 0);
    checkOutput("t4_short", c_short, 1);
    checkOutput("t4_release", c_rel, 1);

    // Test 5: reset while in HELD
    clearCounts();
    applyStimulus(1'b0, 1'b0);
    holdTicks(5);
    checkOutput("t5_in_held", {31'd0, held_a}, 32'd1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t5_held_after_reset", {31'd0, held_a}, 32'd0);
    repeat (10) applyStimulus(1'b0, 1'b0);
    checkOutput("t5_no_release", c_rel, 0);
    checkOutput("t5_no_new_press", c_press, 1);
    releaseFor(3);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t5_press_after_lockout", c_press, 2);
    releaseFor(3);

    // Test 6: repeat disabled instance during a 20-tick hold
    clearCounts();
    applyStimulus(1'b0, 1'b0);
    holdTicks(20);
    releaseFor(3);
    checkOutput("t6_norep_long", c_long0, 1);
    checkOutput("t6_norep_repeat", c_rep0, 0);
    checkOutput("t6_rep_repeat", c_rep, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_events.md
# button_events

Converts one debounced button level, as produced by the debounce filter stage, into clean single-cycle events: press, release, short-click, long-press and auto-repeat. It sits between the debounce filter output and the register and interrupt logic that consumes button activity. All timing is counted in `tick_en` ticks, typically the same 1 kHz strobe that drives the filter, so event timing does not depend on the clock frequency.

## Interface
- `ACTIVE_LOW`, default 1: button level is asserted when `btn`=0; 0 means asserted-high.
- `CNT_WIDTH`, default 12: tick counter width; must hold max(`LONG_TICKS`,`REPEAT_TICKS`)-1.
- `LONG_TICKS`, default 1000: ticks of continuous hold until `long_evt`; must be ≥1.
- `REPEAT_TICKS`, default 200: ticks between `repeat_evt` pulses after a long press; 0 disables repeat.
- `clk`  in  1  system clock, 48 MHz.
- `reset`  in  1  one clock; reset is synchronous and active-high.
- `tick_en`  in  1  single-cycle timebase strobe.
- `btn`  in  1  debounced button level, already synchronous to `clk`.
- `held`  out  1  level output: button is accepted as down.
- `press_evt`  out  1  pulse on accepted press.
- `release_evt`  out  1  pulse on every release that follows an accepted press.
- `short_evt`  out  1  pulse on a release that happens before the long threshold.
- `long_evt`  out  1  pulse when the long threshold is reached.
- `repeat_evt`  out  1  periodic pulse while the button stays held after `long_evt`.

## Operation
- Internal `act` = `btn` XOR `ACTIVE_LOW`. `btn` is used directly, with no extra input register.
- FSM states: LOCKOUT, IDLE, PRESSED, HELD. All outputs are registered.
- LOCKOUT (entered on reset):
  - `act`=0 → IDLE.
  - While `act`=1, no events are produced. A button held through reset never generates a press.
- IDLE:
  - `act`=1 → PRESSED, `press_evt`=1, counter=0.
- PRESSED:
  - `act`=0 → IDLE, with `release_evt`=1 and `short_evt`=1.
  - Otherwise, on `tick_en`, counter+1.
  - If counter==`LONG_TICKS`-1 on a tick → HELD, `long_evt`=1, counter=0.
- HELD:
  - `act`=0 → IDLE, `release_evt`=1, no `short_evt`.
  - Otherwise, if `REPEAT_TICKS`≠0, on `tick_en` counter+1.
  - If counter==`REPEAT_TICKS`-1 on a tick → `repeat_evt`=1, counter=0.
- `held`=1 in PRESSED and HELD.
- Simultaneous release and `tick_en`: release wins. No `long_evt` or `repeat_evt` is produced in that cycle, and the counter is cleared.
- The counter never wraps. It is compared exactly and cleared on every state change.
- `reset` overrides everything, including mid-press: state→LOCKOUT, counter=0, all outputs 0. No release event is emitted.

## Timing
- Reset values: `held`=0 and every `*_evt`=0.
- Latency: when a `btn` change is sampled at edge N, the state, `held` and any event pulse are visible after edge N, for exactly one cycle in the case of events.
- `long_evt` asserts one cycle after the `LONG_TICKS`-th `tick_en` following the press cycle. A tick in the same cycle as the press is not counted.
- With `LONG_TICKS`=L and `REPEAT_TICKS`=R, the k-th `repeat_evt` follows the (L+k·R)-th tick after the press.
- At most one of `press_evt`/`long_evt`/`repeat_evt`/`release_evt` is asserted in any cycle, except that `short_evt` always coincides with `release_evt`.
- A one-cycle press (`act` high for 1 clk) is legal and yields `press_evt`, then `release_evt` and `short_evt` in the next cycle.

## Structure
- State encoding is declared inside the module, since no other block uses it.
- The shared package holds `TICK_HZ` and the default `LONG_TICKS` and `REPEAT_TICKS` constants, so the firmware-visible timing is defined in one place.
- No sub-module: one FSM plus one counter in a single module.
- Elaboration check: `LONG_TICKS`≥1, and both `LONG_TICKS`-1 and `REPEAT_TICKS`-1 fit in `CNT_WIDTH`.

## Test plan
Bench parameters unless noted: `ACTIVE_LOW`=1, `LONG_TICKS`=4, `REPEAT_TICKS`=2, `tick_en` every 5 clk.
1. Reset with `btn`=0 (held), release after 20 clk, press again → no events before the release; `press_evt` exactly once after the second press.
2. Press, release after 2 ticks → `press_evt`, then `release_evt` and `short_evt` together, `held` high only between them, no `long_evt`.
3. Press and hold 9 ticks → `long_evt` after tick 4, `repeat_evt` after ticks 6 and 8, release gives `release_evt` with no `short_evt`.
4. Release in the same cycle as the 4th tick → `release_evt` and `short_evt`, no `long_evt`.
5. Assert `reset` while in HELD → all outputs 0 next cycle, no `release_evt`, lockout until `btn`=1.
6. `REPEAT_TICKS`=0, hold 20 ticks → single `long_evt`, no `repeat_evt`.
